// File: rtl/bsg_credit_returner.sv
// Receiver-side credit source: accumulates consumed entries and returns them in steps of up to max_step_p.
// Latency: a consume is returnable one cycle later at the earliest. Backpressure: credit_ready_i=0 holds credits pending.
// Build option BSG_CREDIT_RETURNER_TIMEOUT_EN batches returns behind a threshold with an idle-flush timer.
module bsg_credit_returner #(
    parameter int max_step_p     = 4,
    parameter int max_pending_p  = 64,
    parameter int threshold_p    = 4,
    parameter int flush_cycles_p = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [$clog2(max_step_p+1)-1:0]      yumi_i,
    input  logic                                 credit_ready_i,
    output logic [$clog2(max_step_p+1)-1:0]      credit_o,
    output logic [$clog2(max_pending_p+1)-1:0]   pending_o,
    output logic                                 overflow_o
);

    localparam int step_w = $clog2(max_step_p + 1);
    localparam int pend_w = $clog2(max_pending_p + 1);
    localparam int sum_w  = pend_w + 1;

    logic [pend_w-1:0] pending_r;
    logic              overflow_r;
    logic [sum_w-1:0]  sum;
    logic              rel_en;
    logic              send_en;

`ifdef BSG_CREDIT_RETURNER_TIMEOUT_EN
    localparam int tmr_w = $clog2(flush_cycles_p + 1);

    logic [tmr_w-1:0] timer_r;

    // Timer measures how long a partial batch has been sitting; ready stalls do not restart it.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            timer_r <= '0;
        end else if ((credit_o != '0) || (pending_r == '0)) begin
            timer_r <= '0;
        end else if (timer_r < tmr_w'(flush_cycles_p)) begin
            timer_r <= timer_r + 1'b1;
        end
    end

    assign rel_en = (pending_r >= pend_w'(threshold_p)) | (timer_r >= tmr_w'(flush_cycles_p));
`else
    logic unused_cfg;

    assign unused_cfg = (threshold_p > flush_cycles_p);
    assign rel_en     = 1'b1;
`endif

    assign send_en = credit_ready_i & (pending_r != '0) & rel_en;

    always_comb begin
        credit_o = '0;
        if (send_en) begin
            if (pending_r > pend_w'(max_step_p)) begin
                credit_o = step_w'(max_step_p);
            end else begin
                credit_o = step_w'(pending_r);
            end
        end
    end

    // credit_o never exceeds pending_r, so the difference cannot go negative.
    assign sum = sum_w'(pending_r) + sum_w'(yumi_i) - sum_w'(credit_o);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pending_r  <= '0;
            overflow_r <= 1'b0;
        end else if (sum > sum_w'(max_pending_p)) begin
            pending_r  <= pend_w'(max_pending_p);
            overflow_r <= 1'b1;
        end else begin
            pending_r  <= pend_w'(sum);
        end
    end

    assign pending_o  = pending_r;
    assign overflow_o = overflow_r;

endmodule

// File: tb/tb_bsg_credit_returner.sv
// Directed bench for bsg_credit_returner; inputs change and outputs are sampled 1ns after the rising edge.
module tb_bsg_credit_returner;

    logic       clk_i;
    logic       reset_i;
    logic [2:0] yumi_i;
    logic       credit_ready_i;
    logic [2:0] credit_o;
    logic [6:0] pending_o;
    logic       overflow_o;

    int passed;
    int total;

    bsg_credit_returner dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .yumi_i         (yumi_i),
        .credit_ready_i (credit_ready_i),
        .credit_o       (credit_o),
        .pending_o      (pending_o),
        .overflow_o     (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        yumi_i         = 3'd0;
        credit_ready_i = 1'b0;
        reset_i        = 1'b1;
        tick();
        reset_i        = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        credit_ready_i = 1'b0;
        yumi_i         = 3'd3;
        tick();
        yumi_i         = 3'd0;
        total++;
        if (pending_o !== 7'd3) $display("FAIL reset_preload: pending_o=%0d expected 3", pending_o);
        else passed++;
        credit_ready_i = 1'b1;
        #2;
        reset_i = 1'b1;
        #1;
        total++;
        if (pending_o !== 7'd0) $display("FAIL reset_async_pending: pending_o=%0d expected 0", pending_o);
        else passed++;
        total++;
        if (credit_o !== 3'd0) $display("FAIL reset_async_credit: credit_o=%0d expected 0", credit_o);
        else passed++;
        total++;
        if (overflow_o !== 1'b0) $display("FAIL reset_async_overflow: overflow_o=%0d expected 0", overflow_o);
        else passed++;
        tick();
        reset_i = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        credit_ready_i = 1'b1;
        yumi_i         = 3'd3;
        #1;
        total++;
        if (credit_o !== 3'd0) $display("FAIL single_no_bypass: credit_o=%0d expected 0", credit_o);
        else passed++;
        tick();
        yumi_i = 3'd0;
        #1;
        total++;
        if (credit_o !== 3'd3) $display("FAIL single_credit: credit_o=%0d expected 3", credit_o);
        else passed++;
        total++;
        if (pending_o !== 7'd3) $display("FAIL single_pending: pending_o=%0d expected 3", pending_o);
        else passed++;
        tick();
        total++;
        if (pending_o !== 7'd0) $display("FAIL single_drained: pending_o=%0d expected 0", pending_o);
        else passed++;
        total++;
        if (credit_o !== 3'd0) $display("FAIL single_idle_credit: credit_o=%0d expected 0", credit_o);
        else passed++;
    endtask

    task automatic test_stalled_batch();
        logic [2:0] exp_c [4];
        logic [6:0] exp_p [4];
        exp_c[0] = 3'd4; exp_c[1] = 3'd4; exp_c[2] = 3'd4; exp_c[3] = 3'd0;
        exp_p[0] = 7'd12; exp_p[1] = 7'd8; exp_p[2] = 7'd4; exp_p[3] = 7'd0;
        do_reset();
        credit_ready_i = 1'b0;
        yumi_i         = 3'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (credit_o !== 3'd0) $display("FAIL stall_credit[%0d]: credit_o=%0d expected 0", i, credit_o);
            else passed++;
        end
        yumi_i         = 3'd0;
        credit_ready_i = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (credit_o !== exp_c[i]) $display("FAIL drain_credit[%0d]: credit_o=%0d expected %0d", i, credit_o, exp_c[i]);
            else passed++;
            total++;
            if (pending_o !== exp_p[i]) $display("FAIL drain_pending[%0d]: pending_o=%0d expected %0d", i, pending_o, exp_p[i]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        credit_ready_i = 1'b0;
        yumi_i         = 3'd4;
        tick();
        yumi_i = 3'd1;
        tick();
        total++;
        if (pending_o !== 7'd5) $display("FAIL simul_preload: pending_o=%0d expected 5", pending_o);
        else passed++;
        credit_ready_i = 1'b1;
        yumi_i         = 3'd2;
        #1;
        total++;
        if (credit_o !== 3'd4) $display("FAIL simul_credit: credit_o=%0d expected 4", credit_o);
        else passed++;
        tick();
        yumi_i = 3'd0;
        #1;
        total++;
        if (pending_o !== 7'd3) $display("FAIL simul_pending: pending_o=%0d expected 3", pending_o);
        else passed++;
        total++;
        if (credit_o !== 3'd3) $display("FAIL simul_partial: credit_o=%0d expected 3", credit_o);
        else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        credit_ready_i = 1'b0;
        yumi_i         = 3'd4;
        for (int i = 0; i < 15; i++) tick();
        yumi_i = 3'd3;
        tick();
        total++;
        if (pending_o !== 7'd63) $display("FAIL ovf_preload: pending_o=%0d expected 63", pending_o);
        else passed++;
        yumi_i = 3'd1;
        tick();
        total++;
        if (pending_o !== 7'd64) $display("FAIL ovf_exact_full: pending_o=%0d expected 64", pending_o);
        else passed++;
        total++;
        if (overflow_o !== 1'b0) $display("FAIL ovf_exact_flag: overflow_o=%0d expected 0", overflow_o);
        else passed++;
        yumi_i = 3'd2;
        tick();
        total++;
        if (pending_o !== 7'd64) $display("FAIL ovf_saturate: pending_o=%0d expected 64", pending_o);
        else passed++;
        total++;
        if (overflow_o !== 1'b1) $display("FAIL ovf_set: overflow_o=%0d expected 1", overflow_o);
        else passed++;
        yumi_i         = 3'd0;
        credit_ready_i = 1'b1;
        tick();
        total++;
        if (pending_o !== 7'd60) $display("FAIL ovf_drain: pending_o=%0d expected 60", pending_o);
        else passed++;
        total++;
        if (overflow_o !== 1'b1) $display("FAIL ovf_sticky: overflow_o=%0d expected 1", overflow_o);
        else passed++;
        #2;
        reset_i = 1'b1;
        #1;
        total++;
        if (overflow_o !== 1'b0) $display("FAIL ovf_reset_clear: overflow_o=%0d expected 0", overflow_o);
        else passed++;
        tick();
        reset_i = 1'b0;
    endtask

`ifdef BSG_CREDIT_RETURNER_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        credit_ready_i = 1'b1;
        yumi_i         = 3'd1;
        tick();
        yumi_i = 3'd0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (credit_o !== 3'd0) $display("FAIL timeout_hold[%0d]: credit_o=%0d expected 0", i, credit_o);
            else passed++;
            tick();
        end
        total++;
        if (credit_o !== 3'd1) $display("FAIL timeout_flush: credit_o=%0d expected 1", credit_o);
        else passed++;
        tick();
        yumi_i = 3'd4;
        tick();
        yumi_i = 3'd0;
        total++;
        if (credit_o !== 3'd4) $display("FAIL timeout_threshold: credit_o=%0d expected 4", credit_o);
        else passed++;
    endtask
`endif

    initial begin
        passed         = 0;
        total          = 0;
        reset_i        = 1'b0;
        yumi_i         = 3'd0;
        credit_ready_i = 1'b0;
        #1;
        test_reset();
        test_single();
        test_stalled_batch();
        test_simultaneous();
        test_overflow();
`ifdef BSG_CREDIT_RETURNER_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
